// File: rtl/ddr_port_arbiter_pkg.sv
// Shared DDR constants for the port arbiter: geometry, master count and FSM encoding.
package ddr_port_arbiter_pkg;

    localparam int BA_BITS     = 3;
    localparam int ROW_BITS    = 14;
    localparam int COL_BITS    = 10;
    localparam int DQ_LEVEL    = 1;
    localparam int NUM_MASTERS = 2;
    localparam int BURST_LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_RESP = 3'd3,
        RD_ADDR = 3'd4,
        RD_DATA = 3'd5
    } arb_state_e;

    // With exactly two masters the index of a one-hot grant is simply its upper bit.
    function automatic logic grant_idx(input logic [NUM_MASTERS-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/ddr_rr_arb.sv
// Two-way arbiter: turns a request vector and the last-granted pointer into a one-hot grant.
module ddr_rr_arb
    import ddr_port_arbiter_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic                   last_ptr,
    output logic [NUM_MASTERS-1:0] gnt
);

    // On a tie the master that was not granted last wins; a lone request is already one-hot.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_ptr ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Two-master arbiter in front of the single ddr_trans port; one transaction in flight at a time.
// Define DDR_ARB_RR_EN for round-robin tie-breaking; otherwise master 0 always wins a tie.
module ddr_port_arbiter
    import ddr_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1,
    parameter int DATA_W = 8 << DQ_LEVEL
) (
    input  logic                               core_clk,
    input  logic                               core_rst,

    input  logic [NUM_MASTERS-1:0]             m_awvalid,
    output logic [NUM_MASTERS-1:0]             m_awready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]      m_awaddr,
    input  logic [NUM_MASTERS*BURST_LEN_W-1:0] m_awlen,
    input  logic [NUM_MASTERS-1:0]             m_wvalid,
    output logic [NUM_MASTERS-1:0]             m_wready,
    input  logic [NUM_MASTERS-1:0]             m_wlast,
    input  logic [NUM_MASTERS*DATA_W-1:0]      m_wdata,
    output logic [NUM_MASTERS-1:0]             m_bvalid,
    input  logic [NUM_MASTERS-1:0]             m_bready,

    input  logic [NUM_MASTERS-1:0]             m_arvalid,
    output logic [NUM_MASTERS-1:0]             m_arready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]      m_araddr,
    input  logic [NUM_MASTERS*BURST_LEN_W-1:0] m_arlen,
    output logic [NUM_MASTERS-1:0]             m_rvalid,
    input  logic [NUM_MASTERS-1:0]             m_rready,
    output logic [NUM_MASTERS-1:0]             m_rlast,
    output logic [DATA_W-1:0]                  m_rdata,

    output logic                               s_awvalid,
    input  logic                               s_awready,
    output logic [ADDR_W-1:0]                  s_awaddr,
    output logic [BURST_LEN_W-1:0]             s_awlen,
    output logic                               s_wvalid,
    input  logic                               s_wready,
    output logic                               s_wlast,
    output logic [DATA_W-1:0]                  s_wdata,
    input  logic                               s_bvalid,
    output logic                               s_bready,
    output logic                               s_arvalid,
    input  logic                               s_arready,
    output logic [ADDR_W-1:0]                  s_araddr,
    output logic [BURST_LEN_W-1:0]             s_arlen,
    input  logic                               s_rvalid,
    output logic                               s_rready,
    input  logic                               s_rlast,
    input  logic [DATA_W-1:0]                  s_rdata,

    output logic [NUM_MASTERS-1:0]             gnt,
    output logic                               busy
);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic                   last_q, last_d;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] arb_gnt;
    logic                   gidx;

    assign req  = m_awvalid | m_arvalid;
    assign gidx = grant_idx(gnt_q);

    ddr_rr_arb u_arb (
        .req      (req),
        .last_ptr (last_q),
        .gnt      (arb_gnt)
    );

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // In the fixed-priority build the pointer never moves off 1, so master 0 keeps every tie.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d   = arb_gnt;
`ifdef DDR_ARB_RR_EN
                    last_d  = grant_idx(arb_gnt);
`endif
                    state_d = m_awvalid[grant_idx(arb_gnt)] ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: begin
                if (!m_awvalid[gidx]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (s_awvalid && s_awready) begin
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (s_wvalid && s_wready && s_wlast) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_bvalid && s_bready) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            RD_ADDR: begin
                if (!m_arvalid[gidx]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (s_arvalid && s_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_rvalid && s_rready && s_rlast) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // Handshakes only pass through in their own phase and only toward the granted master.
    always_comb begin
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_wlast   = 1'b0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        case (state_q)
            WR_ADDR: begin
                s_awvalid       = m_awvalid[gidx];
                m_awready[gidx] = s_awready;
            end
            WR_DATA: begin
                s_wvalid       = m_wvalid[gidx];
                s_wlast        = m_wlast[gidx];
                m_wready[gidx] = s_wready;
            end
            WR_RESP: begin
                s_bready       = m_bready[gidx];
                m_bvalid[gidx] = s_bvalid;
            end
            RD_ADDR: begin
                s_arvalid       = m_arvalid[gidx];
                m_arready[gidx] = s_arready;
            end
            RD_DATA: begin
                s_rready       = m_rready[gidx];
                m_rvalid[gidx] = s_rvalid;
                m_rlast[gidx]  = s_rlast;
            end
            default: begin
                s_awvalid = 1'b0;
            end
        endcase
    end

    assign s_awaddr = gidx ? m_awaddr[ADDR_W +: ADDR_W]           : m_awaddr[0 +: ADDR_W];
    assign s_awlen  = gidx ? m_awlen[BURST_LEN_W +: BURST_LEN_W]  : m_awlen[0 +: BURST_LEN_W];
    assign s_wdata  = gidx ? m_wdata[DATA_W +: DATA_W]            : m_wdata[0 +: DATA_W];
    assign s_araddr = gidx ? m_araddr[ADDR_W +: ADDR_W]           : m_araddr[0 +: ADDR_W];
    assign s_arlen  = gidx ? m_arlen[BURST_LEN_W +: BURST_LEN_W]  : m_arlen[0 +: BURST_LEN_W];

    assign m_rdata = s_rdata;
    assign gnt     = gnt_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: transaction-level model plus directed scenarios.
module tb_ddr_port_arbiter;
    import ddr_port_arbiter_pkg::*;

    localparam int AW = BA_BITS + ROW_BITS + COL_BITS + DQ_LEVEL - 1;
    localparam int DW = 8 << DQ_LEVEL;

    logic          core_clk = 1'b0;
    logic          core_rst = 1'b1;
    logic [1:0]    m_awvalid = '0, m_awready, m_wvalid = '0, m_wready, m_wlast = '0;
    logic [1:0]    m_bvalid, m_bready = '0;
    logic [2*AW-1:0] m_awaddr = '0, m_araddr = '0;
    logic [15:0]   m_awlen = '0, m_arlen = '0;
    logic [2*DW-1:0] m_wdata = '0;
    logic [1:0]    m_arvalid = '0, m_arready, m_rvalid, m_rready = '0, m_rlast;
    logic [DW-1:0] m_rdata;
    logic          s_awvalid, s_awready = 1'b0, s_wvalid, s_wready = 1'b0, s_wlast;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [7:0]    s_awlen, s_arlen;
    logic [DW-1:0] s_wdata, s_rdata = '0;
    logic          s_bvalid = 1'b0, s_bready, s_arvalid, s_arready = 1'b0;
    logic          s_rvalid = 1'b0, s_rready, s_rlast = 1'b0;
    logic [1:0]    gnt;
    logic          busy;

    int checks = 0;
    int errors = 0;

    ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast), .m_wdata(m_wdata),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast), .m_rdata(m_rdata),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast), .s_rdata(s_rdata),
        .gnt(gnt), .busy(busy)
    );

    always #5 core_clk = ~core_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Transaction-level model: who owns the port, what kind of transfer, and which phases are done.
    int         mdl_owner = -1;
    int         mdl_last  = 1;
    bit         mdl_write, mdl_addr_done, mdl_data_done;
    int         o, pick;
    logic [1:0] e_gnt, e_awr, e_wr, e_bv, e_arr, e_rv, e_rl, mreq;
    logic [4:0] e_sctl;

    always @(negedge core_clk) begin
        if (core_rst) begin
            mdl_owner = -1;
            mdl_last  = 1;
        end
        e_gnt = '0; e_sctl = '0;
        e_awr = '0; e_wr = '0; e_bv = '0; e_arr = '0; e_rv = '0; e_rl = '0;
        o = mdl_owner;
        if (o >= 0) begin
            e_gnt[o] = 1'b1;
            if (mdl_write) begin
                if (!mdl_addr_done) begin
                    e_sctl[4] = m_awvalid[o]; e_awr[o] = s_awready;
                end else if (!mdl_data_done) begin
                    e_sctl[3] = m_wvalid[o];  e_wr[o]  = s_wready;
                end else begin
                    e_sctl[2] = m_bready[o];  e_bv[o]  = s_bvalid;
                end
            end else begin
                if (!mdl_addr_done) begin
                    e_sctl[1] = m_arvalid[o]; e_arr[o] = s_arready;
                end else begin
                    e_sctl[0] = m_rready[o];  e_rv[o]  = s_rvalid; e_rl[o] = s_rlast;
                end
            end
        end
        checkOutput("cyc_gnt", gnt, e_gnt);
        checkOutput("cyc_busy", busy, o >= 0);
        checkOutput("cyc_s_ctrl", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, e_sctl);
        checkOutput("cyc_m_wr_hs", {m_awready, m_wready, m_bvalid}, {e_awr, e_wr, e_bv});
        checkOutput("cyc_m_rd_hs", {m_arready, m_rvalid, m_rlast}, {e_arr, e_rv, e_rl});
        checkOutput("cyc_m_rdata", m_rdata, s_rdata);
        if (e_sctl[4]) begin
            checkOutput("cyc_awaddr", s_awaddr, m_awaddr[o*AW +: AW]);
            checkOutput("cyc_awlen", s_awlen, m_awlen[o*8 +: 8]);
        end
        if (e_sctl[3]) begin
            checkOutput("cyc_wdata", s_wdata, m_wdata[o*DW +: DW]);
            checkOutput("cyc_wlast", s_wlast, m_wlast[o]);
        end
        if (e_sctl[1]) begin
            checkOutput("cyc_araddr", s_araddr, m_araddr[o*AW +: AW]);
            checkOutput("cyc_arlen", s_arlen, m_arlen[o*8 +: 8]);
        end
        if (!core_rst) begin
            if (o < 0) begin
                mreq = m_awvalid | m_arvalid;
                if (mreq != 2'b00) begin
`ifdef DDR_ARB_RR_EN
                    pick = (mreq == 2'b11) ? 1 - mdl_last : (mreq[1] ? 1 : 0);
                    mdl_last = pick;
`else
                    pick = mreq[0] ? 0 : 1;
`endif
                    mdl_owner = pick;
                    mdl_write = m_awvalid[pick];
                    mdl_addr_done = 0;
                    mdl_data_done = 0;
                end
            end else if (mdl_write) begin
                if (!mdl_addr_done) begin
                    if (!m_awvalid[o]) mdl_owner = -1;
                    else if (s_awready) mdl_addr_done = 1;
                end else if (!mdl_data_done) begin
                    if (m_wvalid[o] && s_wready && m_wlast[o]) mdl_data_done = 1;
                end else if (s_bvalid && m_bready[o]) begin
                    mdl_owner = -1;
                end
            end else begin
                if (!mdl_addr_done) begin
                    if (!m_arvalid[o]) mdl_owner = -1;
                    else if (s_arready) mdl_addr_done = 1;
                end else if (s_rvalid && m_rready[o] && s_rlast) begin
                    mdl_owner = -1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    // Background handshake levels: everything idle, or every ready/valid/last held high.
    task automatic applyStimulus(input bit all_ready);
        m_awvalid = '0;
        m_arvalid = '0;
        m_wvalid  = all_ready ? 2'b11 : 2'b00;
        m_wlast   = all_ready ? 2'b11 : 2'b00;
        m_bready  = all_ready ? 2'b11 : 2'b00;
        m_rready  = all_ready ? 2'b11 : 2'b00;
        s_awready = all_ready;
        s_wready  = all_ready;
        s_bvalid  = all_ready;
        s_arready = all_ready;
        s_rvalid  = all_ready;
        s_rlast   = all_ready;
    endtask

    task automatic waitIdle(input string name);
        int c = 0;
        while (busy && c < 20) begin
            tick();
            c++;
        end
        checkOutput(name, busy, 1'b0);
    endtask

    task automatic doWrite(input int m, input logic [AW-1:0] addr, input logic [7:0] len);
        m_awvalid[m] = 1'b1;
        m_awaddr[m*AW +: AW] = addr;
        m_awlen[m*8 +: 8] = len;
        s_awready = 1'b1;
        tick();
        #1;
        checkOutput("wr_awvalid", s_awvalid, 1'b1);
        checkOutput("wr_awaddr", s_awaddr, addr);
        checkOutput("wr_gnt", gnt, (m == 0) ? 2'b01 : 2'b10);
        tick();
        m_awvalid[m] = 1'b0;
        s_awready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            m_wvalid[m] = 1'b1;
            m_wlast[m]  = (b == int'(len));
            m_wdata[m*DW +: DW] = DW'(16'hA000 + b);
            s_wready = 1'b1;
            #1;
            checkOutput("wr_beat_valid", s_wvalid, 1'b1);
            checkOutput("wr_beat_data", s_wdata, DW'(16'hA000 + b));
            checkOutput("wr_beat_last", s_wlast, b == int'(len));
            tick();
        end
        m_wvalid[m] = 1'b0;
        m_wlast[m]  = 1'b0;
        s_wready = 1'b0;
        s_bvalid = 1'b1;
        m_bready[m] = 1'b1;
        #1;
        checkOutput("wr_bvalid", m_bvalid, (m == 0) ? 2'b01 : 2'b10);
        tick();
        s_bvalid = 1'b0;
        m_bready[m] = 1'b0;
        #1;
        checkOutput("wr_idle_after", busy, 1'b0);
        checkOutput("wr_bvalid_pulse", m_bvalid, 2'b00);
    endtask

    int         n, m0_grants, beats, rlast_seen;
    bit         drop;
    logic [1:0] prev;
    int         order[3];
    logic [1:0] kinds[2];
    logic [1:0] gnts[2];

    initial begin
        applyStimulus(1'b0);
        tick();
        #1;
        checkOutput("reset_gnt", gnt, 2'b00);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_s_ctrl", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 5'b0);
        tick();
        core_rst = 1'b0;

        // Single write from master 0, four beats.
        tick();
        doWrite(0, AW'(32'h100), 8'd3);

        // Tie after reset between an m0 write and an m1 read, m0 re-requesting once.
        core_rst = 1'b1;
        tick();
        core_rst = 1'b0;
        applyStimulus(1'b1);
        m_awvalid[0] = 1'b1;
        m_arvalid[1] = 1'b1;
        n = 0; m0_grants = 0; prev = '0; drop = 0;
        for (int c = 0; c < 60 && n < 3; c++) begin
            tick();
            if (drop) begin
                m_awvalid[0] = 1'b0;
                drop = 0;
            end
            #1;
            if (gnt != 2'b00 && prev == 2'b00) begin
                order[n] = gnt[1] ? 1 : 0;
                if (!gnt[1]) m0_grants++;
                n++;
            end
            prev = gnt;
            if (m_awready[0] && m0_grants >= 2) drop = 1;
        end
        checkOutput("tie_grant_count", n, 3);
`ifdef DDR_ARB_RR_EN
        checkOutput("tie_order", {order[0][1:0], order[1][1:0], order[2][1:0]}, 6'b00_01_00);
`else
        checkOutput("tie_order", {order[0][1:0], order[1][1:0], order[2][1:0]}, 6'b00_00_01);
`endif
        tick();
        applyStimulus(1'b1);
        waitIdle("tie_idle");

        // m1 write and read together: write first, then read.
        applyStimulus(1'b1);
        m_awvalid[1] = 1'b1;
        m_arvalid[1] = 1'b1;
        n = 0; prev = '0; drop = 0;
        for (int c = 0; c < 40 && n < 2; c++) begin
            tick();
            if (drop) begin
                m_awvalid[1] = 1'b0;
                drop = 0;
            end
            #1;
            if (gnt != 2'b00 && prev == 2'b00) begin
                kinds[n] = {s_awvalid, s_arvalid};
                gnts[n]  = gnt;
                n++;
            end
            prev = gnt;
            if (m_awready[1]) drop = 1;
        end
        checkOutput("wr_rd_count", n, 2);
        checkOutput("wr_rd_first", {gnts[0], kinds[0]}, 4'b10_10);
        checkOutput("wr_rd_second", {gnts[1], kinds[1]}, 4'b10_01);
        tick();
        applyStimulus(1'b1);
        waitIdle("wr_rd_idle");

        // m1 eight-beat read with m_rready toggling.
        applyStimulus(1'b0);
        tick();
        m_arvalid[1] = 1'b1;
        m_araddr[AW +: AW] = AW'(32'h2040);
        m_arlen[15:8] = 8'd7;
        s_arready = 1'b1;
        tick();
        #1;
        checkOutput("rd_arvalid", s_arvalid, 1'b1);
        checkOutput("rd_arlen", s_arlen, 8'd7);
        checkOutput("rd_gnt", gnt, 2'b10);
        tick();
        m_arvalid[1] = 1'b0;
        s_arready = 1'b0;
        beats = 0; rlast_seen = 0;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            m_rready[1] = (c % 2 == 0);
            s_rvalid = 1'b1;
            s_rlast  = (beats == 7);
            s_rdata  = DW'(16'h5500 + beats);
            #1;
            checkOutput("rd_m0_rvalid", m_rvalid[0], 1'b0);
            checkOutput("rd_rlast_8th_only", m_rlast[1], beats == 7);
            if (s_rready) begin
                if (m_rlast[1]) rlast_seen++;
                beats++;
            end
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0; m_rready = '0;
        #1;
        checkOutput("rd_beats", beats, 8);
        checkOutput("rd_rlast_count", rlast_seen, 1);
        checkOutput("rd_idle", busy, 1'b0);

        // Reset during the second write beat.
        applyStimulus(1'b0);
        tick();
        m_awvalid[0] = 1'b1;
        m_awaddr[0 +: AW] = AW'(32'h180);
        m_awlen[7:0] = 8'd3;
        s_awready = 1'b1;
        tick();
        tick();
        m_awvalid[0] = 1'b0;
        s_awready = 1'b0;
        m_wvalid[0] = 1'b1;
        m_wdata[0 +: DW] = DW'(16'hB000);
        s_wready = 1'b1;
        tick();
        m_wdata[0 +: DW] = DW'(16'hB001);
        #1;
        checkOutput("rst_pre_wvalid", s_wvalid, 1'b1);
        core_rst = 1'b1;
        #1;
        checkOutput("rst_gnt", gnt, 2'b00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_s_ctrl", {s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready}, 5'b0);
        checkOutput("rst_m_hs", {m_awready, m_wready, m_bvalid, m_arready, m_rvalid, m_rlast}, 12'b0);
        tick();
        core_rst = 1'b0;
        m_wvalid = '0;
        s_wready = 1'b0;
        s_bvalid = 1'b1;
        m_bready = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput("rst_no_bready", s_bready, 1'b0);
            checkOutput("rst_no_bvalid", m_bvalid, 2'b00);
            tick();
        end
        s_bvalid = 1'b0;
        m_bready = '0;
        doWrite(1, AW'(32'h1C0), 8'd1);

        // m0 withdraws its write address before the slave accepts it.
        applyStimulus(1'b0);
        tick();
        m_awvalid[0] = 1'b1;
        m_awaddr[0 +: AW] = AW'(32'h300);
        tick();
        #1;
        checkOutput("drop_awvalid", s_awvalid, 1'b1);
        checkOutput("drop_awready", m_awready, 2'b00);
        tick();
        m_awvalid[0] = 1'b0;
        #1;
        checkOutput("drop_awvalid_gone", s_awvalid, 1'b0);
        tick();
        #1;
        checkOutput("drop_idle", busy, 1'b0);
        checkOutput("drop_gnt", gnt, 2'b00);
        s_awready = 1'b1;
        tick();
        #1;
        checkOutput("drop_no_issue", {s_awvalid, m_awready}, 3'b000);
        s_awready = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
